life_cell_gen: RTL and testbench
================================

// Module: life_cell_gen
// PURPOSE
//  Parametrised successor to the fixed B3/S23 Life cell. Implements one cell of a life-like
//  or "Generations" automaton with runtime-loadable birth/survive rule masks, multi-state
//  decay, a saturating age counter and a change flag. Tiled in the grid fabric; neighbors
//  come from the alive_q outputs of adjacent cells.
// PARAMETERS
//  NEIGHBORS  8  neighbor inputs (4 = von Neumann, 8 = Moore); must be >= 3
//  STATES     2  cell states C (2 = plain Life, 3..16 = Generations decay); SW = $clog2(STATES)
//  AGE_W      8  age counter width
// PORTS
//  clk          in   1            clock, all logic on posedge
//  rst          in   1            synchronous reset, active-low (cell reset when rst==0)
//  ena          in   1            generation step enable
//  state_0      in   1            reset value: 1 = alive, 0 = dead
//  neighbors    in   NEIGHBORS    alive bits of neighbor cells
//  rule_birth   in   NEIGHBORS+1  bit k set = dead cell with k live neighbors is born
//  rule_survive in   NEIGHBORS+1  bit k set = alive cell with k live neighbors survives
//  rule_load    in   1            capture rule_birth/rule_survive this cycle
//  state_q      out  SW           registered state: 0 dead, 1 alive, 2..STATES-1 dying
//  state_d      out  SW           combinational next state from active rule
//  alive_q      out  1            state_q == 1 (drives neighbors of other cells)
//  age_q        out  AGE_W        consecutive generations survived while alive
//  age_sat      out  1            age_q == all-ones
//  changed_q    out  1            state_q changed at the last ena step
//  rule_pending out  1            a loaded rule is waiting to commit
// BEHAVIOUR
//  - count = popcount(neighbors), width $clog2(NEIGHBORS+1); all indices 0..NEIGHBORS valid.
//  - Next state: dead -> 1 if birth[count] else 0; alive -> 1 if survive[count], else 0
//    when STATES==2, else 2; dying k -> k+1, or 0 when k==STATES-1; ignores neighbors.
//    A dying cell can never be born directly. Only state 1 counts as alive.
//  - Reset (rst==0) has priority over everything: state_q <= state_0; age_q <= 0;
//    changed_q <= 0; active rule <= B3/S23 (birth=1<<3, survive=(1<<2)|(1<<3));
//    rule_pending <= 0. state_d, alive_q and age_sat then follow the reset state.
//  - ena==1 edge: state_q <= state_d; changed_q <= (state_d != state_q);
//    age_q <= (state_q==1 && state_d==1) ? sat_inc(age_q) : 0. age saturates, no wrap.
//  - ena==0: state_q, age_q and changed_q hold.
//  - Rule update, latency 1, never applied mid-step:
//    rule_load & !ena: active <= inputs at this edge; rule_pending <= 0.
//    rule_load & ena: step uses the old active rule; pending <= inputs; rule_pending <= 1.
//    rule_pending & !rule_load: active <= pending at the next edge (any ena); pending clears.
//    rule_pending & rule_load & ena: active <= old pending; pending <= new; stays pending.
//    rule_pending & rule_load & !ena: active <= new inputs; pending is discarded.
//  - state_d always uses the active rule (never pending or raw inputs).
// TESTING
//  1 rst=0, state_0=1, 3 neighbors set, then rst=1 with ena=1 -> state_q=1, age_q 0,1,2;
//    changed_q=0.
//  2 Default rule, dead cell, neighbors=8'b0000_0111, one ena -> state_q=1, changed_q=1,
//    age_q=0; neighbors=0, next ena -> state_q=0, changed_q=1.
//  3 STATES=4, alive cell, count=0, 4 enas with neighbors=8'hFF held -> 2,3,0,0;
//    no birth from a dying state.
//  4 rule_load with ena=1, birth=1<<2 -> that step still uses B3; rule_pending=1 for 1 cycle;
//    next ena with count=2 -> birth.
//  5 Alive, all survive bits set, AGE_W=3, 10 enas -> age_q reaches 7, age_sat=1, holds 7.
//  6 rst=0 during pending load with ena=1 -> rule back to B3/S23, rule_pending=0,
//    state_q=state_0.

Source files
------------

// File: rtl/life_cell_gen.sv
`default_nettype none
// ============================================================================
// Module   : life_cell_gen
// Summary  : One cell of a life-like / Generations automaton. The birth and
//            survive masks can be loaded at runtime, the cell has multi-state
//            decay, a saturating age counter and a change flag.
// Revision : 1.0 - first release
// ============================================================================
module life_cell_gen #(
   parameter  int NEIGHBORS = 8,
   parameter  int STATES    = 2,
   parameter  int AGE_W     = 8,
   localparam int C_SW      = $clog2(STATES)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ena,
   input  logic                 state_0,
   input  logic [NEIGHBORS-1:0] neighbors,
   input  logic [NEIGHBORS:0]   rule_birth,
   input  logic [NEIGHBORS:0]   rule_survive,
   input  logic                 rule_load,
   output logic [C_SW-1:0]      state_q,
   output logic [C_SW-1:0]      state_d,
   output logic                 alive_q,
   output logic [AGE_W-1:0]     age_q,
   output logic                 age_sat,
   output logic                 changed_q,
   output logic                 rule_pending
);

   localparam int              C_CW          = $clog2(NEIGHBORS + 1);
   localparam logic [C_SW-1:0] C_DEAD        = '0;
   localparam logic [C_SW-1:0] C_ALIVE       = C_SW'(1);
   localparam logic [C_SW-1:0] C_LAST        = C_SW'(STATES - 1);
   // With only two states a failed survival goes straight to dead.
   localparam logic [C_SW-1:0] C_FIRST_DYING = (STATES > 2) ? C_SW'(2) : C_DEAD;
   localparam logic [NEIGHBORS:0] C_DEF_BIRTH   = (NEIGHBORS + 1)'(4'b1000);
   localparam logic [NEIGHBORS:0] C_DEF_SURVIVE = (NEIGHBORS + 1)'(4'b1100);

   logic [C_CW-1:0]  w_count;
   logic [NEIGHBORS:0] r_birth;
   logic [NEIGHBORS:0] r_survive;
   logic [NEIGHBORS:0] r_pend_birth;
   logic [NEIGHBORS:0] r_pend_survive;

   // Population count of the live neighbours.
   always_comb begin
      w_count = '0;
      for (int i = 0; i < NEIGHBORS; i++) begin
         w_count = w_count + C_CW'(neighbors[i]);
      end
   end

   // Next state from the active rule; dying cells advance regardless of neighbours.
   always_comb begin
      state_d = state_q;
      if (state_q == C_DEAD) begin
         state_d = r_birth[w_count] ? C_ALIVE : C_DEAD;
      end else if (state_q == C_ALIVE) begin
         state_d = r_survive[w_count] ? C_ALIVE : C_FIRST_DYING;
      end else if (state_q >= C_LAST) begin
         state_d = C_DEAD;
      end else begin
         state_d = state_q + C_SW'(1);
      end
   end

   assign alive_q = (state_q == C_ALIVE);
   assign age_sat = &age_q;

   // Cell state, age and change flag advance only on an enabled step.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= state_0 ? C_ALIVE : C_DEAD;
         age_q     <= '0;
         changed_q <= 1'b0;
      end else if (ena) begin
         state_q   <= state_d;
         changed_q <= (state_d != state_q);
         if ((state_q == C_ALIVE) && (state_d == C_ALIVE)) begin
            age_q <= age_sat ? age_q : age_q + AGE_W'(1);
         end else begin
            age_q <= '0;
         end
      end
   end

   // Rule masks: a load during a step is parked so the step sees the old rule.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_birth        <= C_DEF_BIRTH;
         r_survive      <= C_DEF_SURVIVE;
         r_pend_birth   <= '0;
         r_pend_survive <= '0;
         rule_pending   <= 1'b0;
      end else if (rule_load && !ena) begin
         // Idle cycle: new rule goes live at once, any parked rule is dropped.
         r_birth      <= rule_birth;
         r_survive    <= rule_survive;
         rule_pending <= 1'b0;
      end else if (rule_load) begin
         // Load during a step: commit what was parked, park the new one.
         if (rule_pending) begin
            r_birth   <= r_pend_birth;
            r_survive <= r_pend_survive;
         end
         r_pend_birth   <= rule_birth;
         r_pend_survive <= rule_survive;
         rule_pending   <= 1'b1;
      end else if (rule_pending) begin
         r_birth      <= r_pend_birth;
         r_survive    <= r_pend_survive;
         rule_pending <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_life_cell_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_life_cell_gen
// Summary  : Bench for life_cell_gen. Two instances (plain Life and a
//            4-state Generations cell with a 3-bit age) share one stimulus
//            stream and are compared each cycle against a behavioural model.
// Revision : 1.0 - first release
// ============================================================================
module tb_life_cell_gen;

   localparam logic [8:0] C_B3  = 9'h008;
   localparam logic [8:0] C_S23 = 9'h00C;

   logic       clk;
   logic       rst;
   logic       ena;
   logic       state_0;
   logic [7:0] neighbors;
   logic [8:0] rule_birth;
   logic [8:0] rule_survive;
   logic       rule_load;

   logic [0:0] st_q0, st_d0;
   logic [7:0] age0;
   logic       alive0, sat0, chg0, pend0;
   logic [1:0] st_q1, st_d1;
   logic [2:0] age1;
   logic       alive1, sat1, chg1, pend1;

   int n_cmp = 0;
   int n_err = 0;

   // Model state, index 0 = plain Life instance, 1 = Generations instance.
   int         m_st  [2];
   int         m_age [2];
   int         m_chg [2];
   int         m_nst [2] = '{2, 4};
   int         m_amax[2] = '{255, 7};
   logic [8:0] m_ab, m_as, m_pb, m_ps;
   bit         m_pf;
   bit         m_valid = 0;

   life_cell_gen #(.NEIGHBORS(8), .STATES(2), .AGE_W(8)) u_life (
      .clk(clk), .rst(rst), .ena(ena), .state_0(state_0), .neighbors(neighbors),
      .rule_birth(rule_birth), .rule_survive(rule_survive), .rule_load(rule_load),
      .state_q(st_q0), .state_d(st_d0), .alive_q(alive0), .age_q(age0),
      .age_sat(sat0), .changed_q(chg0), .rule_pending(pend0)
   );

   life_cell_gen #(.NEIGHBORS(8), .STATES(4), .AGE_W(3)) u_gen (
      .clk(clk), .rst(rst), .ena(ena), .state_0(state_0), .neighbors(neighbors),
      .rule_birth(rule_birth), .rule_survive(rule_survive), .rule_load(rule_load),
      .state_q(st_q1), .state_d(st_d1), .alive_q(alive1), .age_q(age1),
      .age_sat(sat1), .changed_q(chg1), .rule_pending(pend1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Generation rule straight from the state definitions.
   function automatic int next_state(int st, int cnt, logic [8:0] b, logic [8:0] sv, int ns);
      if (st == 0) return b[cnt] ? 1 : 0;
      if (st == 1) return sv[cnt] ? 1 : ((ns == 2) ? 0 : 2);
      return (st == ns - 1) ? 0 : st + 1;
   endfunction

   task automatic model_edge(input logic r, e, s0, ld, input logic [8:0] b, sv,
                             input logic [7:0] nb);
      int cnt;
      int nd;
      cnt = $countones(nb);
      if (!r) begin
         for (int k = 0; k < 2; k++) begin
            m_st[k] = s0 ? 1 : 0;
            m_age[k] = 0;
            m_chg[k] = 0;
         end
         m_ab = C_B3;
         m_as = C_S23;
         m_pf = 0;
         m_valid = 1;
         return;
      end
      if (e) begin
         for (int k = 0; k < 2; k++) begin
            nd = next_state(m_st[k], cnt, m_ab, m_as, m_nst[k]);
            m_chg[k] = (nd != m_st[k]) ? 1 : 0;
            if (m_st[k] == 1 && nd == 1) m_age[k] = (m_age[k] < m_amax[k]) ? m_age[k] + 1 : m_age[k];
            else m_age[k] = 0;
            m_st[k] = nd;
         end
      end
      if (ld && !e) begin
         m_ab = b; m_as = sv; m_pf = 0;
      end else if (ld) begin
         if (m_pf) begin m_ab = m_pb; m_as = m_ps; end
         m_pb = b; m_ps = sv; m_pf = 1;
      end else if (m_pf) begin
         m_ab = m_pb; m_as = m_ps; m_pf = 0;
      end
   endtask

   task automatic check_regs();
      check("life.state_q", 32'(st_q0), 32'(m_st[0]));
      check("life.alive_q", 32'(alive0), 32'(m_st[0] == 1));
      check("life.age_q", 32'(age0), 32'(m_age[0]));
      check("life.age_sat", 32'(sat0), 32'(m_age[0] == m_amax[0]));
      check("life.changed_q", 32'(chg0), 32'(m_chg[0]));
      check("life.rule_pending", 32'(pend0), 32'(m_pf));
      check("gen.state_q", 32'(st_q1), 32'(m_st[1]));
      check("gen.alive_q", 32'(alive1), 32'(m_st[1] == 1));
      check("gen.age_q", 32'(age1), 32'(m_age[1]));
      check("gen.age_sat", 32'(sat1), 32'(m_age[1] == m_amax[1]));
      check("gen.changed_q", 32'(chg1), 32'(m_chg[1]));
      check("gen.rule_pending", 32'(pend1), 32'(m_pf));
   endtask

   // One clock: drive, check next-state combinationally, clock, check registers.
   task automatic cycle(input logic r, e, s0, ld, input logic [8:0] b, sv,
                        input logic [7:0] nb);
      int cnt;
      rst = r; ena = e; state_0 = s0; rule_load = ld;
      rule_birth = b; rule_survive = sv; neighbors = nb;
      #1;
      cnt = $countones(nb);
      if (m_valid) begin
         check("life.state_d", 32'(st_d0), 32'(next_state(m_st[0], cnt, m_ab, m_as, 2)));
         check("gen.state_d", 32'(st_d1), 32'(next_state(m_st[1], cnt, m_ab, m_as, 4)));
      end
      @(posedge clk);
      model_edge(r, e, s0, ld, b, sv, nb);
      #1;
      if (m_valid) check_regs();
   endtask

   initial begin
      // Reset to alive with three neighbours, then step under S23.
      cycle(0, 0, 1, 0, C_B3, C_S23, 8'h07);
      check("t1.reset_age", 32'(age0), 32'd0);
      cycle(1, 1, 1, 0, C_B3, C_S23, 8'h07);
      cycle(1, 1, 1, 0, C_B3, C_S23, 8'h07);
      check("t1.age", 32'(age0), 32'd2);
      check("t1.changed", 32'(chg0), 32'd0);

      // Birth from three neighbours, then death with none.
      cycle(0, 0, 0, 0, C_B3, C_S23, 8'h00);
      cycle(1, 1, 0, 0, C_B3, C_S23, 8'h07);
      check("t2.born", 32'(st_q0), 32'd1);
      cycle(1, 1, 0, 0, C_B3, C_S23, 8'h00);
      check("t2.died", 32'(st_q0), 32'd0);
      check("t2.gen_dying", 32'(st_q1), 32'd2);

      // Decay chain with a full neighbourhood: no birth from dying.
      cycle(0, 0, 1, 0, C_B3, C_S23, 8'h00);
      cycle(1, 1, 1, 0, C_B3, C_S23, 8'h00);
      cycle(1, 1, 1, 0, C_B3, C_S23, 8'hFF);
      check("t3.dying3", 32'(st_q1), 32'd3);
      cycle(1, 1, 1, 0, C_B3, C_S23, 8'hFF);
      cycle(1, 1, 1, 0, C_B3, C_S23, 8'hFF);
      check("t3.dead", 32'(st_q1), 32'd0);

      // Load during a step parks the rule; it is live one edge later.
      cycle(0, 0, 0, 0, C_B3, C_S23, 8'h00);
      cycle(1, 1, 0, 1, 9'h004, C_S23, 8'h03);
      check("t4.old_rule", 32'(st_q0), 32'd0);
      check("t4.pending", 32'(pend0), 32'd1);
      cycle(1, 0, 0, 0, C_B3, C_S23, 8'h03);
      check("t4.committed", 32'(pend0), 32'd0);
      cycle(1, 1, 0, 0, C_B3, C_S23, 8'h03);
      check("t4.b2_birth", 32'(st_q0), 32'd1);

      // Age saturation with every survive bit set.
      cycle(0, 0, 1, 0, C_B3, C_S23, 8'h00);
      cycle(1, 0, 1, 1, C_B3, 9'h1FF, 8'h00);
      for (int i = 0; i < 10; i++) cycle(1, 1, 1, 0, C_B3, C_S23, 8'($urandom));
      check("t5.age_sat_gen", 32'(age1), 32'd7);
      check("t5.sat_flag", 32'(sat1), 32'd1);
      check("t5.age_life", 32'(age0), 32'd10);

      // Reset while a rule is parked restores the default rule.
      cycle(0, 0, 0, 0, C_B3, C_S23, 8'h00);
      cycle(1, 1, 0, 1, 9'h004, 9'h000, 8'h00);
      cycle(0, 1, 1, 0, C_B3, C_S23, 8'h00);
      check("t6.pending", 32'(pend0), 32'd0);
      check("t6.state", 32'(st_q0), 32'd1);
      cycle(1, 1, 1, 0, C_B3, C_S23, 8'h00);
      cycle(1, 1, 1, 0, C_B3, C_S23, 8'h03);
      check("t6.b3_back", 32'(st_q0), 32'd0);

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         cycle(($urandom_range(0, 39) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
               ($urandom_range(0, 4) == 0), 9'($urandom), 9'($urandom), 8'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
